// File: rtl/sync_fifo_cnt.sv
// Single-clock valid/ready FIFO with live occupancy count.
// Works for any DEPTH >= 2; pointers wrap explicitly at DEPTH-1, so the depth
// does not have to be a power of two.
// Optional high-water mark: define SYNC_FIFO_CNT_STATS_EN to add the max_count port.

package math_pkg;
    // Smallest w such that 2**w >= n, never less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction
endpackage

module sync_fifo_cnt #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    localparam int PTR_W = math_pkg::clog2(DEPTH),
    localparam int CNT_W = math_pkg::clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] count
`ifdef SYNC_FIFO_CNT_STATS_EN
    ,
    output logic [CNT_W-1:0] max_count
`endif
);

    if (DEPTH < 2) begin : g_depth_check
        $error("sync_fifo_cnt: DEPTH must be >= 2");
    end

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign s_ready = (count_q != CNT_FULL);
    assign m_valid = (count_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Next-state for pointers and occupancy; push and pop are independent.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset drops all stored entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; only valid entries are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

`ifdef SYNC_FIFO_CNT_STATS_EN
    logic [CNT_W-1:0] max_count_q, max_count_d;

    // High-water mark tracks the occupancy that will be present after this edge.
    always_comb begin
        max_count_d = max_count_q;
        if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_count_q <= '0;
        end else begin
            max_count_q <= max_count_d;
        end
    end

    assign max_count = max_count_q;
`endif

`ifndef SYNTHESIS
    int   occ_gap;
    logic occ_ok;

    // Occupancy implied by the pointers; equal pointers mean empty or full.
    always_comb begin
        occ_gap = int'(wr_ptr_q) - int'(rd_ptr_q);
        if (occ_gap < 0) begin
            occ_gap = occ_gap + DEPTH;
        end
        occ_ok = (int'(count_q) == occ_gap) || ((occ_gap == 0) && (int'(count_q) == DEPTH));
    end

    // Consistency checks between count and pointers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= CNT_FULL);
            assert (occ_ok);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_cnt.sv
// Directed bench for sync_fifo_cnt at WIDTH=8, DEPTH=5.
module tb_sync_fifo_cnt;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] count;
`ifdef SYNC_FIFO_CNT_STATS_EN
    logic [CNT_W-1:0] max_count;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo_cnt #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count)
`ifdef SYNC_FIFO_CNT_STATS_EN
        ,
        .max_count(max_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #12 rst_n = 1'b1;

        // Idle after reset
        repeat (3) tick();
        chk("rst_count", count, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);

        // Fill to full with consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h11 + i);
            #1 chk("fill_s_ready", s_ready, 1);
            tick();
        end
        chk("full_s_ready", s_ready, 0);
        chk("full_count", count, 5);
        chk("full_head", m_data, 8'h11);

        // Writes while full are dropped
        s_data = 8'h99;
        repeat (2) tick();
        chk("ovf_count", count, 5);
        chk("ovf_head", m_data, 8'h11);
        s_valid = 1'b0;

        // Drain in order; full blocks s_ready even while popping
        m_ready = 1'b1;
        #1 chk("full_pop_s_ready", s_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_m_valid", m_valid, 1);
            chk("drain_data", m_data, 8'h11 + i);
            tick();
        end
        chk("drained_m_valid", m_valid, 0);
        chk("drained_count", count, 0);
        m_ready = 1'b0;

        // Empty: push does not bypass
        s_valid = 1'b1;
        s_data  = 8'h77;
        #1 chk("empty_no_bypass", m_valid, 0);
        tick();
        chk("one_m_valid", m_valid, 1);
        chk("one_data", m_data, 8'h77);
        chk("one_count", count, 1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("one_popped", count, 0);
        m_ready = 1'b0;

        // Prefill two, then stream 12 with both sides active
        s_valid = 1'b1;
        s_data  = 8'hE0;
        tick();
        s_data  = 8'hE1;
        tick();
        chk("pre_count", count, 2);
        m_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            s_data = 8'(k);
            #1;
            chk("stream_count", count, 2);
            chk("stream_data", m_data, (k < 2) ? (8'hE0 + k) : (k - 2));
            tick();
        end
        s_valid = 1'b0;
        #1 chk("tail0", m_data, 8'h0A);
        tick();
        chk("tail1", m_data, 8'h0B);
        tick();
        chk("stream_empty", count, 0);
        chk("stream_m_valid", m_valid, 0);
        m_ready = 1'b0;

        // Asynchronous reset mid-cycle
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();
        s_data  = 8'h5A;
        tick();
        s_valid = 1'b0;
        chk("pre_rst_count", count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_s_ready", s_ready, 1);
        #3 rst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = 8'h3C;
        tick();
        s_valid = 1'b0;
        chk("post_rst_head", m_data, 8'h3C);
        chk("post_rst_count", count, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("post_rst_empty", count, 0);

`ifdef SYNC_FIFO_CNT_STATS_EN
        // High-water mark: fill 4, drain, refill 2
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'(i);
            tick();
        end
        s_valid = 1'b0;
        chk("hwm_fill", max_count, 4);
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;
        chk("hwm_drained_count", count, 0);
        s_valid = 1'b1;
        repeat (2) tick();
        s_valid = 1'b0;
        chk("hwm_hold", max_count, 4);
        chk("hwm_count", count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
